// File: rtl/pipearch_region_store.sv
// Region storage responder: addressed read/write port plus a FIFO view on the same memory,
// with a fixed two-cycle read latency after the strobe edge and registered fill status.
module pipearch_region_store #(
    parameter int WIDTH              = 512,
    parameter int LOG2_DEPTH         = 9,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  w_we,
    input  logic [LOG2_DEPTH-1:0] w_waddr,
    input  logic                  w_push,
    input  logic [WIDTH-1:0]      w_wdata,
    input  logic                  r_re,
    input  logic [LOG2_DEPTH-1:0] r_raddr,
    input  logic                  r_pop,
    output logic                  r_rvalid,
    output logic [WIDTH-1:0]      r_rdata,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_LEVEL = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] AF_LEVEL   = (LOG2_DEPTH + 1)'(DEPTH - ALMOST_FULL_MARGIN);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr, wr_addr, rd_addr;
    logic [LOG2_DEPTH:0]   count_nx;
    logic                  push_acc, pop_acc, push_rej, pop_rej, wr_en, rd_req;
    logic                  vld_p0, vld_p1;
    logic [WIDTH-1:0]      rdata_p0, rdata_p1;

    // Strobe arbitration: FIFO strobes win over addressed ones, clear masks FIFO strobes only.
    always_comb begin
        pop_acc  = r_pop && !clear && !empty;
        push_acc = w_push && !clear && (!full || pop_acc);
        push_rej = w_push && !clear && !push_acc;
        pop_rej  = r_pop && !clear && !pop_acc;
        wr_en    = push_acc || (w_we && !w_push);
        wr_addr  = w_push ? wr_ptr : w_waddr;
        rd_req   = pop_acc || (r_re && !r_pop);
        rd_addr  = r_pop ? rd_ptr : r_raddr;
        count_nx = count;
        if (clear)
            count_nx = '0;
        else if (push_acc && !pop_acc)
            count_nx = count + 1'b1;
        else if (pop_acc && !push_acc)
            count_nx = count - 1'b1;
    end

    // Stage p0: BRAM write and read-first read on the strobe edge
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= w_wdata;
        if (rd_req)
            rdata_p0 <= mem[rd_addr];
    end

    // Stage p1: BRAM output register; final stage: port output register
    always_ff @(posedge clk) begin
        rdata_p1 <= rdata_p0;
        r_rdata  <= rdata_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            // clear leaves the read valid pipeline running so in-flight reads still answer
            vld_p0      <= rd_req;
            vld_p1      <= vld_p0;
            r_rvalid    <= vld_p1;
            count       <= count_nx;
            empty       <= (count_nx == '0);
            full        <= (count_nx == FULL_LEVEL);
            almost_full <= (count_nx >= AF_LEVEL);
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (push_acc)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_acc)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push_rej)
                    overflow <= 1'b1;
                if (pop_rej)
                    underflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/pipearch_region_store.md
Name: pipearch_region_store

Overview:
- On-chip storage region that answers the accesses issued by the region read/write engines that operator blocks instantiate.
- Implements the responder side of the region access protocol:
  - A write port accepts addressed writes and FIFO pushes.
  - A read port accepts addressed reads and FIFO pops, and returns data after a fixed latency.
- Exports fill status so engines can throttle.
- Sits between operator pipelines (copy, compute) and the BRAM regions they stream through.

Parameters:
WIDTH, 512, data word width in bits
LOG2_DEPTH, 9, log2 of number of words; DEPTH = 2**LOG2_DEPTH
ALMOST_FULL_MARGIN, 4, almost_full asserts when free slots <= this value

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous pointer/count/flag clear; memory contents untouched
w_we  input  1  addressed write strobe
w_waddr  input  LOG2_DEPTH  addressed write address
w_push  input  1  FIFO push strobe (writes at tail, ignores w_waddr)
w_wdata  input  WIDTH  write data for w_we or w_push
r_re  input  1  addressed read strobe
r_raddr  input  LOG2_DEPTH  addressed read address
r_pop  input  1  FIFO pop strobe (reads at head, ignores r_raddr)
r_rvalid  output  1  read data valid
r_rdata  output  WIDTH  read data
count  output  LOG2_DEPTH+1  FIFO occupancy
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= DEPTH - ALMOST_FULL_MARGIN
overflow  output  1  sticky: push attempted while full and no same-cycle pop
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset, clk edge with reset=1:
  - wr_ptr, rd_ptr and count go to 0.
  - r_rvalid pipeline is flushed to 0.
  - overflow and underflow go to 0.
  - Resulting outputs: empty=1, full=0, almost_full=0.
  - r_rdata is don't-care.
  - Memory array is not reset.
- Reset mid-operation drops any in-flight reads; no r_rvalid may appear after reset.
- Write port:
  - Write effective at the clk edge where the strobe is sampled.
  - w_push and w_we in the same cycle: push wins, w_we ignored.
  - Push accepted when !full, or when full with an accepted pop in the same cycle. On accept: mem[wr_ptr] <= w_wdata, wr_ptr <= wr_ptr+1 (wraps modulo DEPTH).
  - Push rejected: no write, overflow <= 1.
- Read port:
  - Fixed latency 2. Strobe sampled at edge t gives r_rvalid=1 with the data for one cycle after edge t+2.
  - Pipeline: registered address/BRAM read, then output register.
  - One response per accepted request, in order.
  - Fully pipelined: a strobe every cycle gives r_rvalid every cycle.
  - No backpressure.
  - r_pop and r_re in the same cycle: pop wins, r_re ignored.
  - Pop accepted when !empty. On accept: read at rd_ptr, rd_ptr <= rd_ptr+1 (wraps).
  - Pop rejected: no response generated, underflow <= 1.
- Read-during-write, same address, same edge: read returns old data (read-first). Applies to FIFO full with push+pop (wr_ptr == rd_ptr): pop returns the old head word.
- Counting:
  - Accepted push without pop: count+1.
  - Accepted pop without push: count-1.
  - Both accepted: count unchanged.
  - Pop while empty is rejected even with a same-cycle push; no bypass.
- Status outputs are registered, updated on the same edge as count.
- clear:
  - Same effect as reset on pointers, count and flags.
  - Dominates push/pop in the same cycle; those strobes are ignored and set no flags.
  - Does NOT flush in-flight reads.
  - Addressed writes in the clear cycle still complete.
- Addressed accesses never affect pointers, count or flags.
- Sticky flags are cleared only by reset or clear.

Test Plan:
- Addressed write/readback: w_we to addr 5 with 0xA5..A5 at edge 0; r_re addr 5 at edge 1 -> r_rvalid at edge 3 with 0xA5..A5; no other r_rvalid pulses.
- FIFO fill/drain, DEPTH=512, margin 4:
  - Push words 0..511 back-to-back -> almost_full first high after the 508th push, full after the 512th.
  - 513th push -> overflow=1, count stays 512.
  - Pop 512 words back-to-back -> r_rvalid 512 consecutive cycles with data 0..511 in order, empty=1 after the last pop.
- Full with simultaneous push+pop: at count=512 push 0xFF while popping -> count stays 512, popped data is the old head word, overflow stays 0.
- Empty with simultaneous push+pop: at count=0 assert both -> underflow=1, count=1, no r_rvalid. A pop next cycle returns the pushed word 2 cycles later.
- Wrap-around: push 300, pop 300, push 400, pop 400 -> data correct across pointer wrap, count ends 0.
- Reset/clear mid-read:
  - Issue 3 reads, assert reset one cycle later -> zero r_rvalid pulses after the reset edge.
  - Repeat with clear instead of reset -> all 3 r_rvalid pulses still appear, count=0 afterwards.
